// File: rtl/l2_mshr_table.sv
// l2_mshr_table: L2 miss-status holding registers with lowest-free allocation, address lookup and deferred free pulses.
// Define L2_MSHR_STATS_EN to add peak-occupancy and alloc-stall statistics.
module l2_mshr_table #(
   parameter int N_MSHR         = 4,
   parameter int MSHR_BITS      = 2,
   parameter int LINE_ADDR_BITS = 28,
   parameter int STATE_BITS     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   input  logic [LINE_ADDR_BITS-1:0] alloc_addr,
   input  logic [STATE_BITS-1:0]     alloc_state,
   output logic [MSHR_BITS-1:0]      alloc_idx,
   input  logic [LINE_ADDR_BITS-1:0] lookup_addr,
   output logic                      lookup_hit,
   output logic [MSHR_BITS-1:0]      lookup_idx,
   output logic [STATE_BITS-1:0]     lookup_state,
   input  logic                      upd_en,
   input  logic [MSHR_BITS-1:0]      upd_idx,
   input  logic [STATE_BITS-1:0]     upd_state,
   input  logic                      free_en,
   input  logic [MSHR_BITS-1:0]      free_idx,
   output logic                      add_mshr_entry,
   output logic [MSHR_BITS-1:0]      mshr_i,
   output logic                      incr_mshr_cnt,
`ifdef L2_MSHR_STATS_EN
   input  logic                      stats_clr,
   output logic [MSHR_BITS:0]        mshr_peak_occ,
   output logic [15:0]               alloc_stall_cnt,
`endif
   output logic                      mshr_empty
);
   logic [N_MSHR-1:0]         valid;
   logic [LINE_ADDR_BITS-1:0] addr_q [N_MSHR];
   logic [STATE_BITS-1:0]     state_q [N_MSHR];
   logic [MSHR_BITS:0]        free_pend;
   logic                      dup;
   logic                      free_fire;

   // descending scan so the lowest matching index is the last one written
   always_comb begin
      alloc_idx = '0;
      lookup_hit = 1'b0;
      lookup_idx = '0;
      lookup_state = '0;
      dup = 1'b0;
      for (int i = N_MSHR - 1; i >= 0; i--) begin
         if (!valid[i]) alloc_idx = MSHR_BITS'(i);
         if (valid[i] && addr_q[i] == alloc_addr) dup = 1'b1;
         if (valid[i] && addr_q[i] == lookup_addr) begin
            lookup_hit = 1'b1;
            lookup_idx = MSHR_BITS'(i);
            lookup_state = state_q[i];
         end
      end
   end

   assign alloc_ready    = !(&valid) && !dup;
   assign add_mshr_entry = alloc_valid && alloc_ready;
   assign mshr_i         = alloc_idx;
   assign free_fire      = free_en && valid[free_idx];
   // the global block drops an increment that collides with a decrement, so hold frees back
   assign incr_mshr_cnt  = (free_pend != '0) && !add_mshr_entry;
   assign mshr_empty     = ~|valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         free_pend <= '0;
         for (int i = 0; i < N_MSHR; i++) begin
            addr_q[i] <= '0;
            state_q[i] <= '0;
         end
      end else begin
         if (upd_en && valid[upd_idx]) state_q[upd_idx] <= upd_state;
         if (add_mshr_entry) begin
            valid[alloc_idx] <= 1'b1;
            addr_q[alloc_idx] <= alloc_addr;
            state_q[alloc_idx] <= alloc_state;
         end
         if (free_fire) valid[free_idx] <= 1'b0;
         free_pend <= free_pend + (MSHR_BITS+1)'(free_fire) - (MSHR_BITS+1)'(incr_mshr_cnt);
      end
   end

`ifdef L2_MSHR_STATS_EN
   logic [MSHR_BITS:0] occ;

   always_comb begin
      occ = '0;
      for (int i = 0; i < N_MSHR; i++) occ = occ + (MSHR_BITS+1)'(valid[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mshr_peak_occ <= '0;
         alloc_stall_cnt <= '0;
      end else if (stats_clr) begin
         mshr_peak_occ <= '0;
         alloc_stall_cnt <= '0;
      end else begin
         if (occ > mshr_peak_occ) mshr_peak_occ <= occ;
         if (alloc_valid && !alloc_ready && !(&alloc_stall_cnt)) alloc_stall_cnt <= alloc_stall_cnt + 16'd1;
      end
   end
`endif
endmodule
